alineador_comas: RTL and testbench
==================================

Name: alineador_comas

Overview:
- Receive-side comma aligner that sits directly upstream of the 8b/10b decoder in the PCIE receiver path.
- Takes the serial bit stream, which is one bit per clkRx, and finds K28.5 comma symbols in it.
- Locks the 10-bit symbol boundary and delivers aligned 10-bit symbols, with a valid strobe, to the decoder.
- Tracks loss of alignment and re-enters search when alignment is lost.

Parameters:
- COMMA_CONF, 3: number of boundary-aligned commas, including the first, needed to go from CONFIRM to LOCKED (range 1..15).
- MISALIGN_MAX, 4: number of consecutive misaligned commas while LOCKED that forces a return to SEARCH (range 1..15).

Ports:
- clkRx  input  1  receive clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- enb  input  1  advance enable; when 0 every register holds.
- rxIdle  input  1  electrical idle from the line; when 1, state is forced to SEARCH.
- serialIn  input  1  serial data, one bit per cycle, bit "a" first.
- symbolOut  output  10  aligned symbol {a,b,c,d,e,i,f,g,h,j}; a = bit 9, the earliest received bit.
- symbolValid  output  1  one-cycle strobe; symbolOut is valid in that cycle.
- k_out  output  1  1 together with symbolValid when symbolOut is a K28.5.
- locked  output  1  1 while state is LOCKED.
- alignState  output  2  00 = SEARCH, 01 = CONFIRM, 10 = LOCKED; 11 is unused.

Behaviour:
- Reset (rst = 0, asynchronous): the following all clear to 0 or their initial value:
  - sr (10-bit shift register), cnt (phase 0..9), confCnt, errCnt;
  - state = SEARCH;
  - symbolOut = 0, symbolValid = 0, k_out = 0, locked = 0.
- Shift register: when enb = 1, sr <= {sr[8:0], serialIn} each cycle.
- Comma match: combinational on the current sr; comma = (sr == 10'b0011111010) or (sr == 10'b1100000101).
- Boundary: a cycle with cnt == 9 while not in SEARCH. cnt increments modulo 10 every enb cycle.
- SEARCH:
  - symbolValid = 0.
  - On comma (at any phase): cnt <= 0, confCnt <= 1, go to CONFIRM. If COMMA_CONF == 1, go straight to LOCKED instead.
  - The matching cycle itself is the first boundary, so the next boundary is 10 enb-cycles later.
- CONFIRM:
  - Comma at a boundary: confCnt++. On reaching COMMA_CONF, go to LOCKED and set errCnt <= 0.
  - Non-comma at a boundary: ignored.
  - Comma at a non-boundary: realign. cnt <= 0, confCnt <= 1, stay in CONFIRM.
- LOCKED, at each boundary:
  - symbolOut <= sr, symbolValid <= 1, k_out <= comma. These are registered, so they appear one cycle after the boundary cycle.
  - Comma at a boundary: errCnt <= 0.
- LOCKED, comma at a non-boundary:
  - errCnt++. No realign while LOCKED.
  - When errCnt reaches MISALIGN_MAX: go to SEARCH, locked <= 0, confCnt <= 0. The cycle that triggers the exit produces no output.
- Symbols emitted: only for boundaries that occur while already LOCKED. The comma that completes confirmation is not emitted.
- symbolValid and k_out: 0 in every non-strobe cycle. symbolOut holds its last value between strobes.
- locked and alignState: registered copies of state (updated with the state register).
- rxIdle = 1 (synchronous, enb-gated):
  - Next state = SEARCH; confCnt and errCnt are cleared.
  - sr keeps shifting.
  - rxIdle overrides any comma event in the same cycle.
- enb = 0: sr, cnt, state and counters all hold; symbolValid = 0 and k_out = 0 that cycle. The boundary is deferred, not lost.
- Reset mid-operation: immediate return to reset values. The next lock needs a full COMMA_CONF sequence.
- A comma straddling a boundary in a pure data stream cannot occur for valid 8b/10b. If one does occur, it is handled as a misaligned comma.

Test Plan:
1. Reset with rst = 0 while serialIn toggles: all outputs 0, alignState = 00. Release rst: outputs stay 0 until a comma arrives.
2. Lock: 5 idle bits, then K28.5- (0011111010), D21.5 (1010101010), K28.5+ (1100000101), D21.5, K28.5-, then D0.0- (1001110100).
   - alignState 00 -> 01 at the first comma, -> 10 after the 3rd comma, locked = 1.
   - Next strobe: symbolValid = 1, symbolOut = 10'b1001110100, k_out = 0.
3. While LOCKED, send K28.5+ on the boundary: strobe with symbolOut = 10'b1100000101, k_out = 1, errCnt = 0.
4. Misalignment:
   - While LOCKED, insert 3 stray bits, then send 4 commas on the new phase.
   - locked stays 1 through 3 misaligned commas and drops on the 4th; alignState = 00.
   - No symbolValid on or after the 4th. Relock after 3 further commas.
5. Confirm realign: in CONFIRM, shift the phase by 1 bit and send a comma. cnt restarts there, and 2 more commas on the new phase give LOCKED.
6. Controls:
   - enb = 0 for 7 cycles mid-symbol: the following strobe is delayed by exactly 7 cycles with an identical symbolOut.
   - rxIdle = 1 for one cycle while LOCKED: alignState = 00 and locked = 0 on the next cycle.

Source files
------------

// File: rtl/alineador_comas.sv
// K28.5 comma aligner: finds the 10-bit symbol boundary in the serial
// receive stream and hands aligned symbols to the 8b/10b decoder.
module alineador_comas #(
    parameter int COMMA_CONF   = 3,
    parameter int MISALIGN_MAX = 4
) (
    input  logic       clkRx,
    input  logic       rst,
    input  logic       enb,
    input  logic       rxIdle,
    input  logic       serialIn,
    output logic [9:0] symbolOut,
    output logic       symbolValid,
    output logic       k_out,
    output logic       locked,
    output logic [1:0] alignState
);

    typedef enum logic [1:0] {
        SEARCH  = 2'b00,
        CONFIRM = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    localparam logic [9:0] K28M   = 10'b0011111010;
    localparam logic [9:0] K28P   = 10'b1100000101;
    localparam logic [3:0] CONF_N = 4'(COMMA_CONF);
    localparam logic [3:0] ERR_N  = 4'(MISALIGN_MAX);

    state_t     state;
    state_t     stateNext;
    logic [9:0] sr;
    logic [3:0] cnt;
    logic [3:0] cntNext;
    logic [3:0] confCnt;
    logic [3:0] confNext;
    logic [3:0] errCnt;
    logic [3:0] errNext;
    logic       comma;
    logic       boundary;
    logic       emit;

    assign comma    = (sr == K28M) || (sr == K28P);
    assign boundary = (cnt == 4'd9) && (state != SEARCH);

    always_comb begin
        stateNext = state;
        cntNext   = (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        confNext  = confCnt;
        errNext   = errCnt;
        emit      = 1'b0;
        // Line idle wins over any comma event in the same cycle
        if (rxIdle) begin
            stateNext = SEARCH;
            confNext  = 4'd0;
            errNext   = 4'd0;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (comma) begin
                        cntNext   = 4'd0;
                        confNext  = 4'd1;
                        errNext   = 4'd0;
                        stateNext = (CONF_N == 4'd1) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (comma && boundary) begin
                        confNext = confCnt + 4'd1;
                        if (confCnt + 4'd1 >= CONF_N) begin
                            stateNext = LOCKED;
                            errNext   = 4'd0;
                        end
                    end else if (comma) begin
                        cntNext  = 4'd0;
                        confNext = 4'd1;
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        emit = 1'b1;
                        if (comma) errNext = 4'd0;
                    end else if (comma) begin
                        // No realign while locked: only count the stray comma
                        if (errCnt + 4'd1 >= ERR_N) begin
                            stateNext = SEARCH;
                            confNext  = 4'd0;
                            errNext   = 4'd0;
                        end else begin
                            errNext = errCnt + 4'd1;
                        end
                    end
                end
                default: stateNext = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clkRx or negedge rst) begin
        if (!rst) begin
            sr          <= '0;
            cnt         <= '0;
            confCnt     <= '0;
            errCnt      <= '0;
            state       <= SEARCH;
            symbolOut   <= '0;
            symbolValid <= 1'b0;
            k_out       <= 1'b0;
            locked      <= 1'b0;
            alignState  <= 2'b00;
        end else if (enb) begin
            sr          <= {sr[8:0], serialIn};
            cnt         <= cntNext;
            confCnt     <= confNext;
            errCnt      <= errNext;
            state       <= stateNext;
            symbolValid <= emit;
            k_out       <= emit & comma;
            locked      <= (stateNext == LOCKED);
            alignState  <= stateNext;
            if (emit) symbolOut <= sr;
        end else begin
            symbolValid <= 1'b0;
            k_out       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alineador_comas.sv
// Scoreboard bench for alineador_comas: directed serial streams with
// hand-derived symbol expectations checked by an independent monitor.
module tb_alineador_comas;

    localparam logic [9:0] KM  = 10'b0011111010;
    localparam logic [9:0] KP  = 10'b1100000101;
    localparam logic [9:0] D21 = 10'b1010101010;
    localparam logic [9:0] D0M = 10'b1001110100;
    localparam logic [9:0] D0P = 10'b0110001011;
    localparam logic [9:0] MIS1 = 10'b1010011111;
    localparam logic [9:0] MIS2 = 10'b0101100000;

    logic       clkRx = 1'b0;
    logic       rst;
    logic       enb;
    logic       rxIdle;
    logic       serialIn;
    logic [9:0] symbolOut;
    logic       symbolValid;
    logic       k_out;
    logic       locked;
    logic [1:0] alignState;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [9:0] sym;
        logic       k;
    } exp_t;

    exp_t sb[$];
    int   strobeCyc[$];
    exp_t e;

    alineador_comas #(.COMMA_CONF(3), .MISALIGN_MAX(4)) dut (
        .clkRx(clkRx),
        .rst(rst),
        .enb(enb),
        .rxIdle(rxIdle),
        .serialIn(serialIn),
        .symbolOut(symbolOut),
        .symbolValid(symbolValid),
        .k_out(k_out),
        .locked(locked),
        .alignState(alignState)
    );

    always #5 clkRx = ~clkRx;

    always @(posedge clkRx) cyc++;

    task automatic check(input string name, input logic [9:0] act,
                         input logic [9:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, req);
        end
    endtask

    always @(negedge clkRx) begin
        if (rst) begin
            if (symbolValid) begin
                strobeCyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected strobe: got %b, want none",
                             symbolOut);
                end else begin
                    e = sb.pop_front();
                    check("symbolOut", symbolOut, e.sym);
                    check("k_out", {9'b0, k_out}, {9'b0, e.k});
                end
            end else begin
                check("k_out idle", {9'b0, k_out}, 10'd0);
            end
        end
    end

    task automatic sendBit(input logic b);
        serialIn = b;
        @(negedge clkRx);
    endtask

    task automatic sendSym(input logic [9:0] s, input bit emit,
                           input logic k, input int holdAt,
                           input int idleAt);
        if (emit) sb.push_back({s, k});
        for (int i = 9; i >= 0; i--) begin
            if (i == holdAt) begin
                enb = 1'b0;
                repeat (7) @(negedge clkRx);
                enb = 1'b1;
            end
            serialIn = s[i];
            rxIdle   = (i == idleAt);
            @(negedge clkRx);
            rxIdle = 1'b0;
            if (i == idleAt) begin
                check("idle state", {8'b0, alignState}, 10'd0);
                check("idle locked", {9'b0, locked}, 10'd0);
            end
        end
    endtask

    task automatic sym(input logic [9:0] s, input bit emit, input logic k);
        sendSym(s, emit, k, -1, -1);
    endtask

    task automatic chkState(input string name, input logic [1:0] st,
                            input logic lk);
        check({name, " state"}, {8'b0, alignState}, {8'b0, st});
        check({name, " locked"}, {9'b0, locked}, {9'b0, lk});
    endtask

    initial begin
        int gap;
        int n;
        rst      = 1'b0;
        enb      = 1'b1;
        rxIdle   = 1'b0;
        serialIn = 1'b0;
        repeat (8) begin
            @(negedge clkRx);
            serialIn = ~serialIn;
        end
        check("rst symbolOut", symbolOut, 10'd0);
        check("rst valid", {9'b0, symbolValid}, 10'd0);
        check("rst k_out", {9'b0, k_out}, 10'd0);
        chkState("rst", 2'b00, 1'b0);
        @(negedge clkRx);
        rst = 1'b1;

        repeat (5) sendBit(1'b0);
        chkState("idle bits", 2'b00, 1'b0);
        check("idle symbolOut", symbolOut, 10'd0);

        sym(KM, 0, 0);
        chkState("comma1 lag", 2'b00, 1'b0);
        sym(D21, 0, 0);
        chkState("confirm", 2'b01, 1'b0);
        sym(KP, 0, 0);
        sym(D21, 0, 0);
        sym(KM, 0, 0);
        chkState("comma3 lag", 2'b01, 1'b0);
        sym(D0M, 1, 0);
        chkState("lock", 2'b10, 1'b1);

        sym(KP, 1, 1);
        sym(D21, 1, 0);

        sb.push_back({MIS1, 1'b0});
        sb.push_back({MIS2, 1'b0});
        sb.push_back({MIS1, 1'b0});
        sb.push_back({MIS2, 1'b0});
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sym(KM, 0, 0);
        sym(KP, 0, 0);
        sym(KM, 0, 0);
        chkState("mis3", 2'b10, 1'b1);
        sym(KP, 0, 0);
        chkState("mis4 lag", 2'b10, 1'b1);
        sym(KM, 0, 0);
        chkState("dropped", 2'b00, 1'b0);
        sym(KP, 0, 0);
        chkState("reconfirm", 2'b01, 1'b0);
        sym(KM, 0, 0);
        sym(D0M, 1, 0);
        chkState("relock", 2'b10, 1'b1);

        sym(D21, 1, 0);
        sendSym(D0M, 1, 0, 5, -1);
        sym(D0P, 1, 0);
        n = strobeCyc.size();
        gap = (n >= 2) ? strobeCyc[n-1] - strobeCyc[n-2] : 0;
        check("hold gap", 10'(gap), 10'd17);
        chkState("pre idle", 2'b10, 1'b1);

        sendSym(D21, 0, 0, -1, 4);

        sym(KM, 0, 0);
        sendBit(1'b1);
        chkState("realign confirm", 2'b01, 1'b0);
        sym(KM, 0, 0);
        sym(KP, 0, 0);
        sym(KM, 0, 0);
        chkState("realign lag", 2'b01, 1'b0);
        sym(D0M, 1, 0);
        chkState("realign lock", 2'b10, 1'b1);

        sendBit(1'b0);
        sendBit(1'b0);
        #2 rst = 1'b0;
        #1;
        check("midrst symbolOut", symbolOut, 10'd0);
        check("midrst valid", {9'b0, symbolValid}, 10'd0);
        chkState("midrst", 2'b00, 1'b0);
        @(negedge clkRx);
        rst = 1'b1;
        repeat (12) sendBit(1'b0);
        check("queue drained", 10'(sb.size()), 10'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
